// File: rtl/rv_seq_ctrl_pkg.sv
// rv_seq_pkg: shared definitions for the RV32 multicycle sequencer.
//   seq_state_t     - sequencer state encoding (3 bits)
//   seq_state_name  - printable state names for simulation debug (TO_SIM only)
package rv_seq_pkg;

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_FETCH = 3'd1,
        S_RS    = 3'd2,
        S_ALU   = 3'd3,
        S_MEM   = 3'd4,
        S_WR    = 3'd5
    } seq_state_t;

`ifdef TO_SIM
    function automatic string seq_state_name(seq_state_t s);
        case (s)
            S_START: return "START";
            S_FETCH: return "FETCH";
            S_RS:    return "RS";
            S_ALU:   return "ALU";
            S_MEM:   return "MEM";
            S_WR:    return "WR";
            default: return "ILLEGAL";
        endcase
    endfunction
`endif

endpackage

// File: rtl/rv_seq_ctrl_if.sv
// rv_seq_ctrl_if: handshake and stage-enable bundle between the sequencer
// and the rest of rv_core (fetch unit, CSR unit, datapath stages).
//   master - the sequencer: samples the i_* requests, drives the o_* enables
//   slave  - the core side: drives the i_* requests, consumes the o_* enables
interface rv_seq_ctrl_if #(
    parameter int ALU_STAGES = 3
);
    logic                  i_fetch_ready;
    logic                  i_mem_op;
    logic                  i_data_ack;
    logic                  i_flush;
    logic                  o_fetch_start;
    logic                  o_rs_en;
    logic [ALU_STAGES-1:0] o_alu_en;
    logic                  o_data_req;
    logic                  o_wr_en;
    logic                  o_instret;
    logic                  o_bus_err;
    logic                  o_busy;

    modport master (
        input  i_fetch_ready, i_mem_op, i_data_ack, i_flush,
        output o_fetch_start, o_rs_en, o_alu_en, o_data_req,
               o_wr_en, o_instret, o_bus_err, o_busy
    );

    modport slave (
        output i_fetch_ready, i_mem_op, i_data_ack, i_flush,
        input  o_fetch_start, o_rs_en, o_alu_en, o_data_req,
               o_wr_en, o_instret, o_bus_err, o_busy
    );
endinterface

// File: rtl/rv_seq_ctrl.sv
// rv_seq_ctrl: multicycle sequencer for the non-pipelined RV32 datapath.
// Ports:
//   i_clk      core clock
//   i_reset_n  asynchronous active-low reset
//   bus        rv_seq_ctrl_if.master: fetch/flush/mem-op/ack in,
//              stage enables, retire, bus error and busy out
// Parameters: ALU_STAGES (1..4), SKIP_MEM (0/1), TIMEOUT (0 = no timeout).
//
// state | meaning
// START | kick off a fetch (o_fetch_start)
// FETCH | wait for the instruction word
// RS    | register read / decode latch
// ALU   | ALU_STAGES cycles, one o_alu_en bit per stage
// MEM   | data access (request held until ack/timeout) or one idle cycle
// WR    | write-back and retire unless errored/flushed; starts next fetch
module rv_seq_ctrl
    import rv_seq_pkg::*;
#(
    parameter int ALU_STAGES = 3,
    parameter int SKIP_MEM   = 1,
    parameter int TIMEOUT    = 0
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    rv_seq_ctrl_if.master bus
);

    localparam int IDX_W = (ALU_STAGES > 1) ? $clog2(ALU_STAGES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ALU_STAGES - 1);
    // Timeout fires in the MEM cycle that would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] WAIT_MAX  = '1;
    localparam bit TMO_EN  = (TIMEOUT > 0);
    localparam bit SKIP_EN = (SKIP_MEM != 0);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] alu_idx_q, alu_idx_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             err_q, err_d;
    logic             flush_q, flush_d;
    logic             mem_q, mem_d;

    logic             req_out;
    logic             ack_hit;
    logic             tmo_hit;

    always_comb begin
        req_out = (state_q == S_MEM) && mem_q;
        ack_hit = req_out && bus.i_data_ack;
        // ack wins over a coincident timeout
        tmo_hit = TMO_EN && req_out && !bus.i_data_ack && (wait_q == WAIT_LAST);
    end

    always_comb begin
        state_d   = state_q;
        alu_idx_d = alu_idx_q;
        wait_d    = wait_q;
        err_d     = err_q;
        flush_d   = flush_q;
        mem_d     = mem_q;

        case (state_q)
            S_START: state_d = S_FETCH;

            S_FETCH: begin
                if (bus.i_flush)            state_d = S_START;
                else if (bus.i_fetch_ready) state_d = S_RS;
            end

            S_RS: begin
                alu_idx_d = '0;
                state_d   = bus.i_flush ? S_START : S_ALU;
            end

            S_ALU: begin
                if (bus.i_flush) begin
                    state_d = S_START;
                end else if (alu_idx_q == LAST_IDX) begin
                    mem_d   = bus.i_mem_op;
                    wait_d  = '0;
                    state_d = (bus.i_mem_op || !SKIP_EN) ? S_MEM : S_WR;
                end else begin
                    alu_idx_d = alu_idx_q + IDX_W'(1);
                end
            end

            S_MEM: begin
                if (mem_q) begin
                    // A flush cannot abandon an outstanding bus request; park
                    // it until the access resolves.
                    if (bus.i_flush) flush_d = 1'b1;
                    if (ack_hit) begin
                        state_d = S_WR;
                    end else if (tmo_hit) begin
                        err_d   = 1'b1;
                        state_d = S_WR;
                    end else if (wait_q != WAIT_MAX) begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end else begin
                    state_d = bus.i_flush ? S_START : S_WR;
                end
            end

            S_WR: begin
                err_d   = 1'b0;
                flush_d = 1'b0;
                state_d = (bus.i_flush || flush_q) ? S_START : S_FETCH;
            end

            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_START;
            alu_idx_q <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            flush_q   <= 1'b0;
            mem_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_idx_q <= alu_idx_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            flush_q   <= flush_d;
            mem_q     <= mem_d;
        end
    end

    // START is the reset state; gating with i_reset_n keeps every output low
    // while reset is held.
    always_comb begin
        bus.o_fetch_start = ((state_q == S_START) && i_reset_n) || (state_q == S_WR);
        bus.o_rs_en       = (state_q == S_RS);
        bus.o_alu_en      = (state_q == S_ALU) ? (ALU_STAGES'(1) << alu_idx_q) : '0;
        bus.o_data_req    = req_out;
        bus.o_wr_en       = (state_q == S_WR) && !err_q && !flush_q;
        bus.o_instret     = (state_q == S_WR) && !err_q && !flush_q;
        // Reported in the suppressed WR cycle that follows the timeout.
        bus.o_bus_err     = (state_q == S_WR) && err_q;
        bus.o_busy        = (state_q != S_FETCH) && i_reset_n;
    end

endmodule

// File: tb/tb_rv_seq_ctrl.sv
module tb_rv_seq_ctrl;

    localparam int A0 = 3, S0 = 1, T0 = 4;
    localparam int A1 = 1, S1 = 0, T1 = 0;
    localparam int NTXN = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       fetch_ready [2];
    logic       mem_op      [2];
    logic       data_ack    [2];
    logic       flush       [2];
    logic       fetch_start [2];
    logic       rs_en       [2];
    logic       data_req    [2];
    logic       wr_en       [2];
    logic       instret     [2];
    logic       bus_err     [2];
    logic       busy        [2];
    logic [3:0] alu_en      [2];

    rv_seq_ctrl_if #(.ALU_STAGES(A0)) if0 ();
    rv_seq_ctrl_if #(.ALU_STAGES(A1)) if1 ();

    assign if0.i_fetch_ready = fetch_ready[0];
    assign if0.i_mem_op      = mem_op[0];
    assign if0.i_data_ack    = data_ack[0];
    assign if0.i_flush       = flush[0];
    assign if1.i_fetch_ready = fetch_ready[1];
    assign if1.i_mem_op      = mem_op[1];
    assign if1.i_data_ack    = data_ack[1];
    assign if1.i_flush       = flush[1];

    assign fetch_start[0] = if0.o_fetch_start;
    assign rs_en[0]       = if0.o_rs_en;
    assign alu_en[0]      = {1'b0, if0.o_alu_en};
    assign data_req[0]    = if0.o_data_req;
    assign wr_en[0]       = if0.o_wr_en;
    assign instret[0]     = if0.o_instret;
    assign bus_err[0]     = if0.o_bus_err;
    assign busy[0]        = if0.o_busy;
    assign fetch_start[1] = if1.o_fetch_start;
    assign rs_en[1]       = if1.o_rs_en;
    assign alu_en[1]      = {3'b000, if1.o_alu_en};
    assign data_req[1]    = if1.o_data_req;
    assign wr_en[1]       = if1.o_wr_en;
    assign instret[1]     = if1.o_instret;
    assign bus_err[1]     = if1.o_bus_err;
    assign busy[1]        = if1.o_busy;

    rv_seq_ctrl #(.ALU_STAGES(A0), .SKIP_MEM(S0), .TIMEOUT(T0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .bus(if0.master)
    );
    rv_seq_ctrl #(.ALU_STAGES(A1), .SKIP_MEM(S1), .TIMEOUT(T1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .bus(if1.master)
    );

    // One instruction as seen on the outputs, from the RS cycle up to and
    // including the cycle that next raises o_fetch_start.
    typedef struct {
        int len;
        int alu;
        int req;
        int wr;
        int ir;
        int be;
        int pre;
        int bad;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b1;

    // directed cases {mem_op, ack_at, flush_offset}; ack_at 0 = never acked,
    // flush_offset counted from the RS cycle, -1 = no flush
    int dir0 [0:6][0:2] = '{'{0,0,-1}, '{1,3,-1}, '{1,0,-1}, '{1,4,-1},
                            '{0,0,2},  '{1,3,5},  '{0,0,4}};
    int dir1 [0:6][0:2] = '{'{0,0,-1}, '{0,0,2},  '{1,1,-1}, '{1,5,-1},
                            '{1,2,1},  '{0,0,0},  '{1,3,4}};

    function automatic int cfg_a(int d); return (d == 0) ? A0 : A1; endfunction
    function automatic int cfg_s(int d); return (d == 0) ? S0 : S1; endfunction
    function automatic int cfg_t(int d); return (d == 0) ? T0 : T1; endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: derive the instruction outcome from the sequencing rules.
    function automatic rec_t model(int d, bit mem, int ack_at, int f);
        rec_t r;
        int   a = cfg_a(d);
        int   t = cfg_t(d);
        int   w;
        bit   to = 1'b0;
        if (mem) begin
            if (t > 0 && (ack_at == 0 || ack_at > t)) begin
                w  = t;
                to = 1'b1;
            end else begin
                w = ack_at;
            end
        end else begin
            w = (cfg_s(d) != 0) ? 0 : 1;
        end
        r.pre = 1; r.bad = 0;
        r.len = a + w + 2;
        r.alu = a;
        r.req = mem ? w : 0;
        r.wr  = to ? 0 : 1;
        r.ir  = to ? 0 : 1;
        r.be  = to ? 1 : 0;
        if (f >= 0) begin
            if (f <= a || (f <= a + w && !mem)) begin
                r.len = f + 2;
                r.alu = (f < a) ? f : a;
                r.req = 0; r.wr = 0; r.ir = 0; r.be = 0;
            end else if (f <= a + w) begin
                r.wr = 0; r.ir = 0;
            end
        end
        return r;
    endfunction

    task automatic stim(int d);
        bit   mem;
        int   ack_at, f, gap, off, reqcnt, cyc;
        bit   started, done;
        rec_t e;
        for (int i = 0; i < NTXN; i++) begin
            if (i < 7) begin
                mem    = (d == 0) ? (dir0[i][0] != 0) : (dir1[i][0] != 0);
                ack_at = (d == 0) ? dir0[i][1] : dir1[i][1];
                f      = (d == 0) ? dir0[i][2] : dir1[i][2];
            end else begin
                mem    = ($urandom_range(0, 1) != 0);
                ack_at = (cfg_t(d) == 0) ? $urandom_range(1, 5) : $urandom_range(0, 6);
                e      = model(d, mem, ack_at, -1);
                f      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, e.len - 1) : -1;
            end
            e = model(d, mem, ack_at, f);
            if (d == 0) q0.push_back(e); else q1.push_back(e);

            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk); #2;
                flush[d]    = 1'b0;
                data_ack[d] = ($urandom_range(0, 1) != 0);
            end
            fetch_ready[d] = 1'b1;
            mem_op[d]      = mem;
            started = 1'b0; done = 1'b0; off = 0; reqcnt = 0; cyc = 0;
            while (!done) begin
                @(posedge clk); #2;
                cyc++;
                if (!started && rs_en[d]) begin
                    started        = 1'b1;
                    off            = 0;
                    fetch_ready[d] = 1'b0;
                end else if (started) begin
                    off++;
                end
                if (started) begin
                    flush[d] = (off == f);
                    if (data_req[d]) begin
                        reqcnt++;
                        data_ack[d] = (reqcnt == ack_at);
                    end else begin
                        data_ack[d] = ($urandom_range(0, 1) != 0);
                    end
                    if (fetch_start[d]) done = 1'b1;
                end else begin
                    flush[d]    = 1'b0;
                    data_ack[d] = ($urandom_range(0, 1) != 0);
                end
                if (cyc > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL d%0d_txn%0d_bound: got no completion after %0d cycles, required under 200", d, i, cyc);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #2;
        flush[d] = 1'b0; data_ack[d] = 1'b0; fetch_ready[d] = 1'b0;
    endtask

    task automatic monitor(int d);
        bit   open = 1'b0;
        bit   pbusy = 1'b1;
        bit   pfr = 1'b0;
        int   off = 0;
        logic [3:0] expa;
        rec_t r, e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                open = 1'b0;
            end else begin
                if (!open && rs_en[d]) begin
                    open  = 1'b1;
                    off   = 0;
                    r     = '{default: 0};
                    r.pre = (!pbusy && pfr) ? 1 : 0;
                end
                if (open) begin
                    if (alu_en[d] != 4'd0) begin
                        r.alu++;
                        expa = (off >= 1 && off <= 4) ? 4'(1 << (off - 1)) : 4'd0;
                        if (alu_en[d] != expa) r.bad = 1;
                    end
                    r.req += int'(data_req[d]);
                    r.wr  += int'(wr_en[d]);
                    r.ir  += int'(instret[d]);
                    r.be  += int'(bus_err[d]);
                    if (fetch_start[d]) begin
                        r.len = off + 1;
                        open  = 1'b0;
                        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL d%0d_unexpected_txn: got a completed instruction, required none pending", d);
                        end else begin
                            e = (d == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("d%0d_len", d),        r.len, e.len);
                            chk($sformatf("d%0d_alu_cycles", d), r.alu, e.alu);
                            chk($sformatf("d%0d_alu_order", d),  r.bad, e.bad);
                            chk($sformatf("d%0d_req_cycles", d), r.req, e.req);
                            chk($sformatf("d%0d_wr_en", d),      r.wr,  e.wr);
                            chk($sformatf("d%0d_instret", d),    r.ir,  e.ir);
                            chk($sformatf("d%0d_bus_err", d),    r.be,  e.be);
                            chk($sformatf("d%0d_fetch_wait", d), r.pre, e.pre);
                        end
                    end else begin
                        off++;
                        if (off > 300) begin
                            checks++;
                            failures++;
                            $display("FAIL d%0d_open_txn: got no fetch_start after %0d cycles, required under 300", d, off);
                            open = 1'b0;
                        end
                    end
                end
            end
            pbusy = busy[d];
            pfr   = fetch_ready[d];
        end
    endtask

    task automatic chk_quiet(string tag, int d);
        chk($sformatf("%s_d%0d_fetch_start", tag, d), int'(fetch_start[d]), 0);
        chk($sformatf("%s_d%0d_busy", tag, d),        int'(busy[d]), 0);
        chk($sformatf("%s_d%0d_rs_en", tag, d),       int'(rs_en[d]), 0);
        chk($sformatf("%s_d%0d_alu_en", tag, d),      int'(alu_en[d]), 0);
        chk($sformatf("%s_d%0d_data_req", tag, d),    int'(data_req[d]), 0);
        chk($sformatf("%s_d%0d_wr_en", tag, d),       int'(wr_en[d]), 0);
        chk($sformatf("%s_d%0d_instret", tag, d),     int'(instret[d]), 0);
        chk($sformatf("%s_d%0d_bus_err", tag, d),     int'(bus_err[d]), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            fetch_ready[d] = 1'b0; mem_op[d] = 1'b0;
            data_ack[d] = 1'b0;    flush[d] = 1'b0;
        end
        fork
            monitor(0);
            monitor(1);
        join_none

        #2;
        for (int d = 0; d < 2; d++) chk_quiet("in_reset", d);
        #10 rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_reset_d%0d_fetch_start", d), int'(fetch_start[d]), 1);
            chk($sformatf("post_reset_d%0d_busy", d),        int'(busy[d]), 1);
            chk($sformatf("post_reset_d%0d_bus_err", d),     int'(bus_err[d]), 0);
        end

        fork
            stim(0);
            stim(1);
        join
        repeat (3) @(posedge clk);
        chk("d0_pending_left", q0.size(), 0);
        chk("d1_pending_left", q1.size(), 0);

        // reset in the middle of an outstanding data request
        mon_en = 1'b0;
        @(posedge clk); #2;
        fetch_ready[0] = 1'b1; mem_op[0] = 1'b1; data_ack[0] = 1'b0; flush[0] = 1'b0;
        for (int k = 0; k < 50 && !data_req[0]; k++) begin
            @(posedge clk); #2;
        end
        fetch_ready[0] = 1'b0;
        chk("mid_mem_reached", int'(data_req[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk_quiet("mid_mem_reset", 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_mem_release_fetch_start", int'(fetch_start[0]), 1);
        chk("mid_mem_release_busy",        int'(busy[0]), 1);
        chk("mid_mem_release_bus_err",     int'(bus_err[0]), 0);
        chk("mid_mem_release_data_req",    int'(data_req[0]), 0);
        @(posedge clk); #2;
        chk("after_release_fetch_start", int'(fetch_start[0]), 0);
        chk("after_release_busy",        int'(busy[0]), 0);
        chk("after_release_bus_err",     int'(bus_err[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_seq_ctrl.md
# rv_seq_ctrl

Parametrised multicycle sequencer for the RV32 core: generates the per-stage enables (fetch start, register read, N ALU stages, memory access, write-back) that drive the non-pipelined datapath. Successor to the core's fixed seven-state sequencer. Adds a configurable ALU stage count, a memory stage that holds `o_data_req` until `i_data_ack`, optional memory-stage skip for non-memory instructions, a data-bus timeout, and a flush input for traps. Sits in `rv_core` between `rv_fetch`/CSR unit and the ALU/memory/write stages.

## Interface
- `ALU_STAGES`, 3: number of ALU cycles per instruction, legal range 1..4.
- `SKIP_MEM`, 1: 1 = non-memory instructions go directly from last ALU stage to WR; 0 = they spend one idle MEM cycle.
- `TIMEOUT`, 0: maximum MEM cycles waiting for `i_data_ack`; 0 disables the timeout.

- `i_clk`  in  1  core clock.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_fetch_ready`  in  1  instruction word valid from `rv_fetch`.
- `i_mem_op`  in  1  current instruction is a load or store; sampled in the last ALU stage.
- `i_data_ack`  in  1  data bus acknowledge.
- `i_flush`  in  1  trap/redirect request from the CSR unit; abort and refetch.
- `o_fetch_start`  out  1  starts the next fetch (pulse).
- `o_rs_en`  out  1  register-read / decode latch enable.
- `o_alu_en`  out  ALU_STAGES  one-hot; bit k high during ALU stage k.
- `o_data_req`  out  1  data bus request.
- `o_wr_en`  out  1  register write-back enable.
- `o_instret`  out  1  one-cycle pulse per retired instruction.
- `o_bus_err`  out  1  one-cycle pulse on data-bus timeout.
- `o_busy`  out  1  high in every state except FETCH.

## Operation
- States: START, FETCH, RS, ALU, MEM, WR. ALU uses a stage counter `alu_idx` (0..ALU_STAGES-1).
- START: assert `o_fetch_start`, then go to FETCH.
- FETCH: hold until `i_fetch_ready`, then go to RS.
- RS: assert `o_rs_en` for one cycle, then go to ALU with `alu_idx`=0.
- ALU: `o_alu_en[alu_idx]`=1 and increment `alu_idx`. At the last stage:
  - if `i_mem_op`, go to MEM;
  - otherwise go to MEM if `SKIP_MEM`=0, or to WR if `SKIP_MEM`=1.
- MEM with a latched memory op: `o_data_req`=1 combinationally every MEM cycle until the cycle in which `i_data_ack`=1, then go to WR.
- MEM without a memory op: one cycle, `o_data_req`=0, then go to WR.
- Timeout: the wait counter increments each MEM cycle without ack. When it reaches `TIMEOUT` (TIMEOUT>0) with no ack:
  - pulse `o_bus_err`, set the `err` flag, and go to WR;
  - in that WR, suppress `o_wr_en` and `o_instret`.
- WR: `o_wr_en`=!`err`, `o_instret`=!`err`, `o_fetch_start`=1; then go to FETCH and clear `err`.
- `i_flush` in FETCH, RS, ALU, or in MEM without an outstanding request: next state START, no write-back, no instret.
- `i_flush` in MEM with an outstanding request is deferred (latched) until the ack or timeout. The following WR is then suppressed and the next state is START instead of FETCH.
- `i_flush` in WR: write-back completes normally; next state is START.
- Ack and timeout in the same cycle: the ack wins, with no `o_bus_err`.
- `i_data_ack` outside an outstanding request is ignored.

## Timing
- Asynchronous reset: state START, `alu_idx`=0, wait counter=0, `err`=0, flush latch=0.
- All outputs are decoded from state, so outputs are 0 in reset except as START dictates: `o_fetch_start`=1 and `o_busy`=1 while reset is deasserted in START.
- Cycles per non-memory instruction from `i_fetch_ready`: 1 (RS) + ALU_STAGES + (SKIP_MEM ? 0 : 1) + 1 (WR).
- Memory instruction: 1 + ALU_STAGES + W + 1, where W ≥ 1 MEM cycles (ack in the first MEM cycle gives W=1).
- The wait counter width is $clog2(TIMEOUT+1) and it saturates. It is cleared on MEM entry.
- `i_mem_op` is sampled only in the last ALU stage. `i_fetch_ready` is observed only in FETCH.

## Structure
- Shared package `rv_seq_pkg` holds `seq_state_t` (enum, 3 bits) and the state-name debug strings used under TO_SIM.
- No sub-module needed. The optional `rv_seq_timeout` counter may be split out only if it is reused by the fetch unit.

## Test plan
- ALU_STAGES=3, SKIP_MEM=1, non-memory op, `i_fetch_ready` at t0 -> `o_rs_en` at t0+1, `o_alu_en` 001/010/100 at t0+2..t0+4, `o_wr_en`+`o_instret`+`o_fetch_start` at t0+5.
- Load with `i_data_ack` at the 3rd MEM cycle (SKIP_MEM=1) -> `o_data_req` high for exactly 3 cycles, WR on the next cycle, one `o_instret`.
- TIMEOUT=4, no ack -> `o_data_req` high 4 cycles, `o_bus_err` pulse, WR with `o_wr_en`=0 and `o_instret`=0, then FETCH.
- `i_flush` in ALU stage 1 -> START next cycle, no `o_wr_en`. `i_flush` during an outstanding MEM request -> request held until ack, suppressed WR, then START.
- ALU_STAGES=1, SKIP_MEM=0, non-memory op -> RS, ALU, MEM (`o_data_req`=0), WR: 4 cycles after `i_fetch_ready`.
- Assert `i_reset_n` low mid-MEM -> all outputs drop asynchronously. After release: START, `o_fetch_start`=1, no `o_bus_err`.
